pll_rst_seq: RTL
================

# pll_rst_seq

Parametrised clock-domain reset sequencer that sits directly behind the GateMate PLL wrapper on the buffered PLL output clock. It synchronises the raw PLL lock flag into the clock domain and requires it to be stable for a programmable number of cycles. It then releases NUM_RST active-low domain resets one at a time, STAGGER cycles apart. Loss of lock or a software reset request re-asserts every domain reset, and the block optionally counts lock-loss events for debug.

## Interface
Parameters:
- SYNC_STAGES, 2: synchroniser flops on pll_lock_raw; legal range 2..4.
- LOCK_FILTER, 16: consecutive synced-high cycles required before lock is accepted; must be ≥1.
- NUM_RST, 4: number of staggered domain reset outputs; legal range 1..16.
- STAGGER, 8: cycles between successive domain releases; must be ≥1.
- CNT_W, 8: width of the lock-loss counter.

Ports:
- clock_in  in  1  buffered PLL output clock; the block's only clock.
- rst_in  in  1  asynchronous, active-low reset, synchronously deasserted upstream.
- pll_lock_raw  in  1  PLL lock flag; asynchronous to clock_in.
- soft_rst  in  1  synchronous request to re-run the release sequence; level sampled each cycle.
- locked  out  1  filtered lock; reset 0.
- rst_n_out  out  NUM_RST  domain resets, active-low; reset all 0.
- ready  out  1  all domains released; reset 0.
- lock_loss_cnt  out  CNT_W  saturating count of lock losses; reset 0.

## Operation
- The FSM has five states: IDLE, WAIT_LOCK, FILTER, RELEASE, RUN. Reset places it in IDLE. IDLE moves to WAIT_LOCK unconditionally on the next cycle.
- sync_lock is the last flop of the SYNC_STAGES chain. The synchroniser flops reset to 0.
- WAIT_LOCK: rst_n_out is all 0, locked=0, ready=0. When sync_lock=1, go to FILTER with filt_cnt=0.
- FILTER: filt_cnt increments each cycle while sync_lock=1.
  - When sync_lock=0, return to WAIT_LOCK.
  - When filt_cnt == LOCK_FILTER-1 with sync_lock=1, set locked=1 and go to RELEASE with idx=0 and tmr=0.
- RELEASE: tmr counts 0..STAGGER-1.
  - When tmr == STAGGER-1, set rst_n_out[idx]=1, clear tmr and increment idx.
  - When idx == NUM_RST-1 is released, go to RUN and set ready=1 in the same cycle.
  - Released bits stay high; bits are released in ascending order only.
- RUN: hold all outputs.
- Lock loss: sync_lock=0 while in FILTER, RELEASE or RUN.
  - In RELEASE or RUN it clears rst_n_out, locked and ready on the next edge and moves to WAIT_LOCK.
  - In RELEASE or RUN it also increments lock_loss_cnt. The counter saturates at 2^CNT_W-1.
  - A lock drop during FILTER is not counted.
- soft_rst=1 in RUN or RELEASE (with lock still valid): clear rst_n_out and ready, keep locked=1, go to RELEASE with idx=0 and tmr=0. The release sequence restarts once soft_rst returns to 0: RELEASE holds tmr at 0 while soft_rst=1.
- soft_rst in IDLE, WAIT_LOCK or FILTER is ignored.
- Lock loss and soft_rst in the same cycle: lock loss wins, and the counter increments.
- rst_in asserted at any time: all outputs go to their reset values asynchronously, including lock_loss_cnt.

## Timing
- Synchroniser latency is SYNC_STAGES cycles from pll_lock_raw rising to sync_lock=1.
- locked rises LOCK_FILTER cycles after FILTER is entered, counting the entry cycle.
- rst_n_out[i] rises (i+1)·STAGGER cycles after locked rises.
- ready rises in the same cycle as rst_n_out[NUM_RST-1].
- Lock-loss response: outputs fall one cycle after sync_lock falls, which is SYNC_STAGES+1 cycles after pll_lock_raw falls.
- All outputs are registered; there is no combinational path from input to output.

## Configuration
- With PLL_RST_SEQ_LOSS_CNT_EN defined: the CNT_W-bit saturating lock-loss counter is built and behaves as described above.
- Without it: the counter logic is not synthesised and lock_loss_cnt is tied to 0. All other behaviour is identical.

## Test plan
All scenarios use the defaults: SYNC_STAGES=2, LOCK_FILTER=16, NUM_RST=4, STAGGER=8.
1. Power-up:
   - Stimulus: release rst_in, raise pll_lock_raw at cycle 10.
   - Required: locked=1 at cycle 10+2+1+16; rst_n_out goes 0001, 0011, 0111, 1111 at +8, +16, +24, +32 cycles after that; ready=1 together with 1111.
2. Lock glitch during FILTER:
   - Stimulus: drop pll_lock_raw for 1 cycle after 10 filter cycles.
   - Required: returns to WAIT_LOCK; the filter restarts from 0; lock_loss_cnt stays 0.
3. Lock loss in RUN:
   - Stimulus: drop pll_lock_raw.
   - Required: rst_n_out=0000, locked=0 and ready=0 three cycles later; lock_loss_cnt=1; the full sequence repeats when lock returns.
4. soft_rst in RUN, held 5 cycles:
   - Required: rst_n_out=0000 and ready=0 on the next cycle; locked stays 1; rst_n_out[0] rises 8 cycles after soft_rst falls.
5. Saturation:
   - Stimulus: CNT_W=2, 5 lock losses from RUN.
   - Required: lock_loss_cnt=3. Without PLL_RST_SEQ_LOSS_CNT_EN, lock_loss_cnt=0 throughout.
6. Async reset during RELEASE:
   - Stimulus: assert rst_in with rst_n_out=0011.
   - Required: all outputs are 0 immediately, before the next clock edge.

Source files
------------

// File: rtl/pll_rst_seq.sv
// rtl/pll_rst_seq.sv - PLL lock filter and staggered domain reset release; lock-loss counter built only with PLL_RST_SEQ_LOSS_CNT_EN
module pll_rst_seq #(
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_FILTER = 16,
  parameter int NUM_RST     = 4,
  parameter int STAGGER     = 8,
  parameter int CNT_W       = 8
) (
  input  logic               clock_in,
  input  logic               rst_in,
  input  logic               pll_lock_raw,
  input  logic               soft_rst,
  output logic               locked,
  output logic [NUM_RST-1:0] rst_n_out,
  output logic               ready,
  output logic [CNT_W-1:0]   lock_loss_cnt
);

  // Counter widths never collapse to zero bits, even for 1-cycle settings.
  localparam int FILT_W = (LOCK_FILTER > 1) ? $clog2(LOCK_FILTER) : 1;
  localparam int TMR_W  = (STAGGER > 1) ? $clog2(STAGGER) : 1;
  localparam int IDX_W  = (NUM_RST > 1) ? $clog2(NUM_RST) : 1;

  localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(LOCK_FILTER - 1);
  localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'(STAGGER - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_RST - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_FILTER    = 3'd2,
    S_RELEASE   = 3'd3,
    S_RUN       = 3'd4
  } state_t;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_sync_lock;

  state_t                 r_state;
  logic [FILT_W-1:0]      r_filt_cnt;
  logic [TMR_W-1:0]       r_tmr;
  logic [IDX_W-1:0]       r_idx;
  logic                   r_locked;
  logic [NUM_RST-1:0]     r_rst_n;
  logic                   r_ready;

`ifdef PLL_RST_SEQ_LOSS_CNT_EN
  logic [CNT_W-1:0]       r_loss_cnt;
`endif

  assign w_sync_lock = r_sync[SYNC_STAGES-1];

  // Bring the asynchronous lock flag into the clock domain.
  always_ff @(posedge clock_in or negedge rst_in) begin
    if (!rst_in) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], pll_lock_raw};
    end
  end

  // Sequencer: filter lock, release domains one by one, tear down on lock loss or soft reset.
  always_ff @(posedge clock_in or negedge rst_in) begin
    if (!rst_in) begin
      r_state    <= S_IDLE;
      r_filt_cnt <= '0;
      r_tmr      <= '0;
      r_idx      <= '0;
      r_locked   <= 1'b0;
      r_rst_n    <= '0;
      r_ready    <= 1'b0;
`ifdef PLL_RST_SEQ_LOSS_CNT_EN
      r_loss_cnt <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          r_state <= S_WAIT_LOCK;
        end

        S_WAIT_LOCK: begin
          r_locked <= 1'b0;
          r_rst_n  <= '0;
          r_ready  <= 1'b0;
          if (w_sync_lock) begin
            r_filt_cnt <= '0;
            r_state    <= S_FILTER;
          end
        end

        S_FILTER: begin
          // A drop here is just an unstable lock, not a loss worth counting.
          if (!w_sync_lock) begin
            r_state <= S_WAIT_LOCK;
          end else if (r_filt_cnt == FILT_LAST) begin
            r_locked <= 1'b1;
            r_idx    <= '0;
            r_tmr    <= '0;
            r_state  <= S_RELEASE;
          end else begin
            r_filt_cnt <= r_filt_cnt + 1'b1;
          end
        end

        S_RELEASE, S_RUN: begin
          if (!w_sync_lock) begin
            // Lock loss takes priority over a concurrent soft reset.
            r_locked <= 1'b0;
            r_rst_n  <= '0;
            r_ready  <= 1'b0;
            r_state  <= S_WAIT_LOCK;
`ifdef PLL_RST_SEQ_LOSS_CNT_EN
            if (r_loss_cnt != {CNT_W{1'b1}}) begin
              r_loss_cnt <= r_loss_cnt + 1'b1;
            end
`endif
          end else if (soft_rst) begin
            // Held soft reset pins the release timer at zero.
            r_rst_n <= '0;
            r_ready <= 1'b0;
            r_idx   <= '0;
            r_tmr   <= '0;
            r_state <= S_RELEASE;
          end else if (r_state == S_RELEASE) begin
            if (r_tmr == TMR_LAST) begin
              r_rst_n <= r_rst_n | (NUM_RST'(1) << r_idx);
              r_tmr   <= '0;
              r_idx   <= r_idx + 1'b1;
              if (r_idx == IDX_LAST) begin
                r_ready <= 1'b1;
                r_state <= S_RUN;
              end
            end else begin
              r_tmr <= r_tmr + 1'b1;
            end
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign locked    = r_locked;
  assign rst_n_out = r_rst_n;
  assign ready     = r_ready;

`ifdef PLL_RST_SEQ_LOSS_CNT_EN
  assign lock_loss_cnt = r_loss_cnt;
`else
  assign lock_loss_cnt = '0;
`endif

endmodule
